// File: rtl/mem_access_unit_if.sv
// Execute-to-memory op channel, data-bus request/response and writeback result.
// master is the memory-access unit's view; slave is the surrounding pipeline and bus.
interface mem_access_unit_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_addr;
  logic [31:0] in_wdata;
  logic [2:0]  in_op;
  logic        flush;
  logic        dreq_valid;
  logic        dreq_write;
  logic [31:0] dreq_addr;
  logic [3:0]  dreq_strobe;
  logic [31:0] dreq_data;
  logic        dresp_addr_ok;
  logic        dresp_data_ok;
  logic [31:0] dresp_data;
  logic        out_valid;
  logic [31:0] out_rdata;
  logic        out_adel;
  logic        out_ades;
  logic        out_bus_err;
  logic [31:0] out_badvaddr;

  modport master (
    input  in_valid, in_addr, in_wdata, in_op, flush,
    input  dresp_addr_ok, dresp_data_ok, dresp_data,
    output in_ready,
    output dreq_valid, dreq_write, dreq_addr, dreq_strobe, dreq_data,
    output out_valid, out_rdata, out_adel, out_ades, out_bus_err,
    output out_badvaddr
  );

  modport slave (
    output in_valid, in_addr, in_wdata, in_op, flush,
    output dresp_addr_ok, dresp_data_ok, dresp_data,
    input  in_ready,
    input  dreq_valid, dreq_write, dreq_addr, dreq_strobe, dreq_data,
    input  out_valid, out_rdata, out_adel, out_ades, out_bus_err,
    input  out_badvaddr
  );
endinterface

// File: rtl/mem_access_unit.sv
// Memory-access stage: alignment check, one data-bus transaction per op,
// load extension and address-error/timeout reporting to writeback.
module mem_access_unit #(
  parameter int TIMEOUT_CYCLES = 0,
  parameter int CNT_W          = 16
) (
  input logic clk,
  input logic reset,
  mem_access_unit_if.master bus
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT, EXC} state_e;

  localparam logic [2:0] OP_LB  = 3'd0;
  localparam logic [2:0] OP_LBU = 3'd1;
  localparam logic [2:0] OP_LH  = 3'd2;
  localparam logic [2:0] OP_LHU = 3'd3;
  localparam logic [2:0] OP_LW  = 3'd4;
  localparam logic [2:0] OP_SB  = 3'd5;
  localparam logic [2:0] OP_SH  = 3'd6;
  localparam logic [2:0] OP_SW  = 3'd7;
  localparam logic [CNT_W-1:0] TO_LIM = CNT_W'(TIMEOUT_CYCLES);

  state_e      state_q, state_d;
  logic [2:0]  op_q, op_d;
  logic [31:0] addr_q, addr_d;
  logic        kill_q, kill_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic        in_ready_q, in_ready_d;
  logic        dreq_valid_q, dreq_valid_d;
  logic        dreq_write_q, dreq_write_d;
  logic [31:0] dreq_addr_q, dreq_addr_d;
  logic [3:0]  dreq_strobe_q, dreq_strobe_d;
  logic [31:0] dreq_data_q, dreq_data_d;
  logic        out_valid_q, out_valid_d;
  logic [31:0] out_rdata_q, out_rdata_d;
  logic        out_adel_q, out_adel_d;
  logic        out_ades_q, out_ades_d;
  logic        out_bus_err_q, out_bus_err_d;
  logic [31:0] out_badvaddr_q, out_badvaddr_d;

  logic        in_st, st_q, misal, accept, timeout;
  logic        done_ok, done_err, killed;
  logic [3:0]  strobe_n;
  logic [31:0] data_n, word, ext;

  always_comb begin : decode
    in_st    = bus.in_op inside {OP_SB, OP_SH, OP_SW};
    misal    = 1'b0;
    strobe_n = 4'b0000;
    data_n   = 32'h0;
    unique case (bus.in_op)
      OP_LH, OP_LHU: misal = bus.in_addr[0];
      OP_LW:         misal = |bus.in_addr[1:0];
      OP_SB: begin
        strobe_n = 4'b0001 << bus.in_addr[1:0];
        data_n   = {4{bus.in_wdata[7:0]}};
      end
      OP_SH: begin
        misal    = bus.in_addr[0];
        strobe_n = bus.in_addr[1] ? 4'b1100 : 4'b0011;
        data_n   = {2{bus.in_wdata[15:0]}};
      end
      OP_SW: begin
        misal    = |bus.in_addr[1:0];
        strobe_n = 4'b1111;
        data_n   = bus.in_wdata;
      end
      default: ;
    endcase
  end

  always_comb begin : extract
    word = bus.dresp_data >> {addr_q[1:0], 3'b000};
    unique case (op_q)
      OP_LB:   ext = {{24{word[7]}}, word[7:0]};
      OP_LBU:  ext = {24'h0, word[7:0]};
      OP_LH:   ext = {{16{word[15]}}, word[15:0]};
      OP_LHU:  ext = {16'h0, word[15:0]};
      default: ext = word;
    endcase
  end

  assign st_q    = op_q inside {OP_SB, OP_SH, OP_SW};
  assign cnt_inc = cnt_q + 1'b1;
  assign timeout = (TIMEOUT_CYCLES > 0) && (cnt_inc == TO_LIM);
  assign killed  = kill_q | bus.flush;

  always_comb begin : next
    state_d        = state_q;
    op_d           = op_q;
    addr_d         = addr_q;
    kill_d         = kill_q;
    cnt_d          = cnt_q;
    dreq_valid_d   = dreq_valid_q;
    dreq_write_d   = dreq_write_q;
    dreq_addr_d    = dreq_addr_q;
    dreq_strobe_d  = dreq_strobe_q;
    dreq_data_d    = dreq_data_q;
    out_valid_d    = 1'b0;
    out_rdata_d    = 32'h0;
    out_adel_d     = 1'b0;
    out_ades_d     = 1'b0;
    out_bus_err_d  = 1'b0;
    out_badvaddr_d = 32'h0;
    done_ok        = 1'b0;
    done_err       = 1'b0;
    accept = bus.in_valid && in_ready_q && !bus.flush;
    unique case (state_q)
      IDLE: if (accept) begin
        op_d          = bus.in_op;
        addr_d        = bus.in_addr;
        kill_d        = 1'b0;
        cnt_d         = '0;
        dreq_write_d  = in_st;
        dreq_addr_d   = {bus.in_addr[31:2], 2'b00};
        dreq_strobe_d = strobe_n;
        dreq_data_d   = data_n;
        dreq_valid_d  = !misal;
        state_d       = misal ? EXC : REQ;
      end
      REQ: begin
        kill_d = killed;
        cnt_d  = cnt_inc;
        // data_ok without addr_ok is a protocol violation and is ignored
        if (bus.dresp_addr_ok && bus.dresp_data_ok) begin
          done_ok = 1'b1;
        end else if (timeout) begin
          done_err = 1'b1;
        end else if (bus.dresp_addr_ok) begin
          dreq_valid_d = 1'b0;
          state_d      = WAIT;
        end
      end
      WAIT: begin
        kill_d = killed;
        cnt_d  = cnt_inc;
        if (bus.dresp_data_ok) done_ok = 1'b1;
        else if (timeout)      done_err = 1'b1;
      end
      EXC: begin
        state_d = IDLE;
        if (!bus.flush) begin
          out_valid_d    = 1'b1;
          out_adel_d     = !st_q;
          out_ades_d     = st_q;
          out_badvaddr_d = addr_q;
        end
      end
      default: state_d = IDLE;
    endcase
    if (done_ok || done_err) begin
      state_d      = IDLE;
      dreq_valid_d = 1'b0;
      kill_d       = 1'b0;
      if (!killed) begin
        out_valid_d   = 1'b1;
        out_bus_err_d = done_err;
        out_rdata_d   = (done_ok && !st_q) ? ext : 32'h0;
      end
    end
    in_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      op_q           <= 3'd0;
      addr_q         <= 32'h0;
      kill_q         <= 1'b0;
      cnt_q          <= '0;
      in_ready_q     <= 1'b1;
      dreq_valid_q   <= 1'b0;
      dreq_write_q   <= 1'b0;
      dreq_addr_q    <= 32'h0;
      dreq_strobe_q  <= 4'b0000;
      dreq_data_q    <= 32'h0;
      out_valid_q    <= 1'b0;
      out_rdata_q    <= 32'h0;
      out_adel_q     <= 1'b0;
      out_ades_q     <= 1'b0;
      out_bus_err_q  <= 1'b0;
      out_badvaddr_q <= 32'h0;
    end else begin
      state_q        <= state_d;
      op_q           <= op_d;
      addr_q         <= addr_d;
      kill_q         <= kill_d;
      cnt_q          <= cnt_d;
      in_ready_q     <= in_ready_d;
      dreq_valid_q   <= dreq_valid_d;
      dreq_write_q   <= dreq_write_d;
      dreq_addr_q    <= dreq_addr_d;
      dreq_strobe_q  <= dreq_strobe_d;
      dreq_data_q    <= dreq_data_d;
      out_valid_q    <= out_valid_d;
      out_rdata_q    <= out_rdata_d;
      out_adel_q     <= out_adel_d;
      out_ades_q     <= out_ades_d;
      out_bus_err_q  <= out_bus_err_d;
      out_badvaddr_q <= out_badvaddr_d;
    end
  end

  assign bus.in_ready     = in_ready_q;
  assign bus.dreq_valid   = dreq_valid_q;
  assign bus.dreq_write   = dreq_write_q;
  assign bus.dreq_addr    = dreq_addr_q;
  assign bus.dreq_strobe  = dreq_strobe_q;
  assign bus.dreq_data    = dreq_data_q;
  assign bus.out_valid    = out_valid_q;
  assign bus.out_rdata    = out_rdata_q;
  assign bus.out_adel     = out_adel_q;
  assign bus.out_ades     = out_ades_q;
  assign bus.out_bus_err  = out_bus_err_q;
  assign bus.out_badvaddr = out_badvaddr_q;
endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: vector table plus flush, timeout,
// reset and protocol corner sequences on a timeout and a no-timeout instance.
module tb_mem_access_unit;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mem_access_unit_if b();
  mem_access_unit_if b0();

  mem_access_unit #(.TIMEOUT_CYCLES(8), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .bus(b)
  );
  mem_access_unit #(.TIMEOUT_CYCLES(0), .CNT_W(16)) dut0 (
    .clk(clk), .reset(reset), .bus(b0)
  );

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        exc;
    logic [3:0]  strobe;
    logic [31:0] dq;
    logic [31:0] rres;
  } vec_t;

  vec_t v[17];

  task automatic run_vec(input vec_t t, input int i);
    logic st;
    st = (t.op >= 3'd5);
    b.in_valid = 1'b1;
    b.in_op    = t.op;
    b.in_addr  = t.addr;
    b.in_wdata = t.wdata;
    cyc();
    b.in_valid = 1'b0;
    b.in_addr  = 32'hFFFF_FFFF;
    b.in_wdata = 32'h0;
    chk($sformatf("v%0d_in_ready_busy", i), b.in_ready, 0);
    chk($sformatf("v%0d_dreq_valid", i), b.dreq_valid, !t.exc);
    if (!t.exc) begin
      chk($sformatf("v%0d_dreq_addr", i), b.dreq_addr, {t.addr[31:2], 2'b00});
      chk($sformatf("v%0d_strobe", i), b.dreq_strobe, t.strobe);
      chk($sformatf("v%0d_write", i), b.dreq_write, st);
      if (st) chk($sformatf("v%0d_dreq_data", i), b.dreq_data, t.dq);
      b.dresp_addr_ok = 1'b1;
      b.dresp_data_ok = 1'b1;
      b.dresp_data    = t.rdata;
    end
    cyc();
    b.dresp_addr_ok = 1'b0;
    b.dresp_data_ok = 1'b0;
    chk($sformatf("v%0d_out_valid", i), b.out_valid, 1);
    chk($sformatf("v%0d_rdata", i), b.out_rdata, t.rres);
    chk($sformatf("v%0d_adel", i), b.out_adel, t.exc && !st);
    chk($sformatf("v%0d_ades", i), b.out_ades, t.exc && st);
    chk($sformatf("v%0d_bus_err", i), b.out_bus_err, 0);
    chk($sformatf("v%0d_badvaddr", i), b.out_badvaddr, t.exc ? t.addr : 32'h0);
    chk($sformatf("v%0d_in_ready", i), b.in_ready, 1);
    cyc();
    chk($sformatf("v%0d_pulse_end", i), b.out_valid, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    int hit;
    logic seen;
    v[0]  = '{3'd0, 32'h1003, 32'h0, 32'h80FF_1234, 1'b0, 4'b0000, 32'h0, 32'hFFFF_FF80};
    v[1]  = '{3'd6, 32'h2002, 32'hAAAA_BEEF, 32'hFFFF_FFFF, 1'b0, 4'b1100, 32'hBEEF_BEEF, 32'h0};
    v[2]  = '{3'd4, 32'h3001, 32'h0, 32'h0, 1'b1, 4'b0000, 32'h0, 32'h0};
    v[3]  = '{3'd1, 32'h1002, 32'h0, 32'h80FF_1234, 1'b0, 4'b0000, 32'h0, 32'h0000_00FF};
    v[4]  = '{3'd2, 32'h1002, 32'h0, 32'h80FF_1234, 1'b0, 4'b0000, 32'h0, 32'hFFFF_80FF};
    v[5]  = '{3'd3, 32'h1000, 32'h0, 32'h80FF_1234, 1'b0, 4'b0000, 32'h0, 32'h0000_1234};
    v[6]  = '{3'd4, 32'h1004, 32'h0, 32'hDEAD_BEEF, 1'b0, 4'b0000, 32'h0, 32'hDEAD_BEEF};
    v[7]  = '{3'd5, 32'h5001, 32'h1234_56A5, 32'hFFFF_FFFF, 1'b0, 4'b0010, 32'hA5A5_A5A5, 32'h0};
    v[8]  = '{3'd5, 32'h5003, 32'h1234_56A5, 32'hFFFF_FFFF, 1'b0, 4'b1000, 32'hA5A5_A5A5, 32'h0};
    v[9]  = '{3'd7, 32'h6000, 32'hCAFE_F00D, 32'hFFFF_FFFF, 1'b0, 4'b1111, 32'hCAFE_F00D, 32'h0};
    v[10] = '{3'd6, 32'h2001, 32'h0, 32'h0, 1'b1, 4'b0000, 32'h0, 32'h0};
    v[11] = '{3'd3, 32'h4003, 32'h0, 32'h0, 1'b1, 4'b0000, 32'h0, 32'h0};
    v[12] = '{3'd7, 32'h6002, 32'h0, 32'h0, 1'b1, 4'b0000, 32'h0, 32'h0};
    v[13] = '{3'd6, 32'h2000, 32'h1234_ABCD, 32'hFFFF_FFFF, 1'b0, 4'b0011, 32'hABCD_ABCD, 32'h0};
    v[14] = '{3'd0, 32'h1001, 32'h0, 32'h80FF_1234, 1'b0, 4'b0000, 32'h0, 32'h0000_0012};
    v[15] = '{3'd2, 32'h1000, 32'h0, 32'h0000_8001, 1'b0, 4'b0000, 32'h0, 32'hFFFF_8001};
    v[16] = '{3'd0, 32'h1000, 32'h0, 32'h0000_007F, 1'b0, 4'b0000, 32'h0, 32'h0000_007F};

    b.in_valid = 0; b.in_addr = 0; b.in_wdata = 0; b.in_op = 0; b.flush = 0;
    b.dresp_addr_ok = 0; b.dresp_data_ok = 0; b.dresp_data = 0;
    b0.in_valid = 0; b0.in_addr = 0; b0.in_wdata = 0; b0.in_op = 0; b0.flush = 0;
    b0.dresp_addr_ok = 0; b0.dresp_data_ok = 0; b0.dresp_data = 0;

    @(negedge clk);
    chk("rst_in_ready", b.in_ready, 1);
    chk("rst_out_valid", b.out_valid, 0);
    chk("rst_dreq_valid", b.dreq_valid, 0);
    chk("rst_dreq_addr", b.dreq_addr, 0);
    chk("rst_out_rdata", b.out_rdata, 0);
    chk("rst0_in_ready", b0.in_ready, 1);
    cyc();
    reset = 1'b0;
    cyc();

    for (int i = 0; i < 17; i++) run_vec(v[i], i);

    // flush in IDLE blocks accept
    b.in_valid = 1; b.in_op = 3'd4; b.in_addr = 32'h1000; b.flush = 1;
    cyc();
    b.in_valid = 0; b.flush = 0;
    chk("flush_idle_ready", b.in_ready, 1);
    chk("flush_idle_dreq", b.dreq_valid, 0);

    // flush during EXC suppresses the exception
    b.in_valid = 1; b.in_op = 3'd4; b.in_addr = 32'h3002;
    cyc();
    b.in_valid = 0; b.flush = 1;
    cyc();
    b.flush = 0;
    chk("flush_exc_valid", b.out_valid, 0);
    chk("flush_exc_adel", b.out_adel, 0);
    chk("flush_exc_ready", b.in_ready, 1);

    // data_ok ahead of addr_ok is ignored
    b.in_valid = 1; b.in_op = 3'd4; b.in_addr = 32'h1010;
    cyc();
    b.in_valid = 0;
    b.dresp_data_ok = 1; b.dresp_data = 32'h1111_1111;
    cyc();
    chk("early_dok_valid", b.out_valid, 0);
    chk("early_dok_dreq", b.dreq_valid, 1);
    b.dresp_addr_ok = 1; b.dresp_data = 32'h2222_3333;
    cyc();
    b.dresp_addr_ok = 0; b.dresp_data_ok = 0;
    chk("early_dok_out", b.out_valid, 1);
    chk("early_dok_rdata", b.out_rdata, 32'h2222_3333);
    cyc();

    // LHU with addr_ok late and flush in cycle 2
    b.in_valid = 1; b.in_op = 3'd3; b.in_addr = 32'h4000;
    cyc();
    b.in_valid = 0; b.in_addr = 32'hFFFF_FFFF;
    seen = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      b.flush = (c == 2);
      chk($sformatf("fl_dreq_valid_c%0d", c), b.dreq_valid, 1);
      chk($sformatf("fl_dreq_addr_c%0d", c), b.dreq_addr, 32'h4000);
      chk($sformatf("fl_strobe_c%0d", c), b.dreq_strobe, 0);
      chk($sformatf("fl_write_c%0d", c), b.dreq_write, 0);
      seen |= b.out_valid;
      cyc();
    end
    b.flush = 0;
    b.dresp_addr_ok = 1;
    chk("fl_dreq_valid_c4", b.dreq_valid, 1);
    cyc();
    b.dresp_addr_ok = 0; b.dresp_data_ok = 1; b.dresp_data = 32'h0000_5678;
    chk("fl_dreq_dropped", b.dreq_valid, 0);
    chk("fl_busy", b.in_ready, 0);
    seen |= b.out_valid;
    cyc();
    b.dresp_data_ok = 0;
    seen |= b.out_valid;
    chk("fl_ready_back", b.in_ready, 1);
    cyc();
    seen |= b.out_valid;
    chk("fl_never_valid", seen, 0);

    // timeout with addr_ok never asserted
    b.in_valid = 1; b.in_op = 3'd4; b.in_addr = 32'h7000;
    cyc();
    b.in_valid = 0;
    hit = 0;
    for (int k = 1; k <= 20 && hit == 0; k++) begin
      cyc();
      if (b.out_valid) hit = k;
      else chk($sformatf("to_dreq_held_k%0d", k), b.dreq_valid, 1);
    end
    chk("to_cycle", hit, 8);
    chk("to_bus_err", b.out_bus_err, 1);
    chk("to_rdata", b.out_rdata, 0);
    chk("to_dreq_valid", b.dreq_valid, 0);
    chk("to_in_ready", b.in_ready, 1);
    cyc();

    // no-timeout instance rides out a long stall
    b0.in_valid = 1; b0.in_op = 3'd4; b0.in_addr = 32'h100C;
    cyc();
    b0.in_valid = 0;
    seen = 1'b0;
    for (int k = 0; k < 12; k++) begin
      seen |= b0.out_valid | !b0.dreq_valid;
      cyc();
    end
    chk("nto_stall_quiet", seen, 0);
    b0.dresp_addr_ok = 1; b0.dresp_data_ok = 1; b0.dresp_data = 32'h55AA_1234;
    cyc();
    b0.dresp_addr_ok = 0; b0.dresp_data_ok = 0;
    chk("nto_out_valid", b0.out_valid, 1);
    chk("nto_rdata", b0.out_rdata, 32'h55AA_1234);
    chk("nto_bus_err", b0.out_bus_err, 0);
    cyc();

    // reset while in WAIT, then a stale data_ok
    b.in_valid = 1; b.in_op = 3'd4; b.in_addr = 32'h1008;
    cyc();
    b.in_valid = 0; b.dresp_addr_ok = 1;
    cyc();
    b.dresp_addr_ok = 0;
    chk("rw_wait_dreq", b.dreq_valid, 0);
    chk("rw_wait_busy", b.in_ready, 0);
    #2 reset = 1'b1;
    #1;
    chk("rw_in_ready", b.in_ready, 1);
    chk("rw_out_valid", b.out_valid, 0);
    chk("rw_dreq_valid", b.dreq_valid, 0);
    @(negedge clk);
    reset = 1'b0;
    b.dresp_data_ok = 1; b.dresp_data = 32'h9999_9999;
    cyc();
    b.dresp_data_ok = 0;
    chk("rw_late_dok", b.out_valid, 0);
    chk("rw_ready_after", b.in_ready, 1);
    cyc();
    chk("rw_late_dok2", b.out_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
